// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings and constants for the HI/LO multiply/divide unit
package mips_pkg;
   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam int MD_STEPS = 32;
   typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t;
endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: issue/result bundle between decode and the multiply/divide unit
interface hilo_muldiv_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] x;
   logic [31:0] y;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   modport master (output start, op, x, y, input busy, done, hi, lo);
   modport slave (input start, op, x, y, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement of a 64-bit value or of its two 32-bit halves
module muldiv_signfix (
   input  logic [63:0] v,
   input  logic        wide,
   input  logic        neg_hi,
   input  logic        neg_lo,
   output logic [63:0] r
);
   always_comb
      r = wide ? (neg_hi ? -v : v)
               : {neg_hi ? -v[63:32] : v[63:32], neg_lo ? -v[31:0] : v[31:0]};
endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: iterative 32-step multiply/divide owning the MIPS HI/LO registers
module hilo_muldiv
   import mips_pkg::*;
(
   input logic          clk,
   input logic          rst,
   hilo_muldiv_if.slave bus
);
   md_state_t   state, state_n;
   logic [4:0]  cnt;
   logic [63:0] acc, step, res, mag;
   logic [31:0] opd, dif;
   logic [32:0] sum, r_sh;
   logic        is_div, neg_hi, neg_lo, sgn, sx, sy, ge;
   always_comb begin
      sgn = bus.op == MD_MULT || bus.op == MD_DIV;
      sx = sgn & bus.x[31];
      sy = sgn & bus.y[31];
      sum = {1'b0, acc[63:32]} + {1'b0, acc[0] ? opd : 32'd0};
      r_sh = {acc[63:32], acc[31]};
      dif = r_sh[31:0] - opd;
      ge = r_sh >= {1'b0, opd};
      step = is_div ? {ge ? dif : r_sh[31:0], acc[30:0], ge} : {sum, acc[31:1]};
   end
   muldiv_signfix u_opd (.v({bus.x, bus.y}), .wide(1'b0), .neg_hi(sx), .neg_lo(sy), .r(mag));
   muldiv_signfix u_res (.v(acc), .wide(!is_div), .neg_hi(neg_hi), .neg_lo(neg_lo), .r(res));
   always_comb
      state_n = state == MD_IDLE ? (bus.start && bus.op <= MD_DIVU ? MD_CALC : MD_IDLE)
              : state == MD_CALC ? (cnt == 5'(MD_STEPS - 1) ? MD_FIX : MD_CALC)
              : MD_IDLE;
   always_ff @(posedge clk)
      state <= rst ? MD_IDLE : state_n;
   assign bus.busy = state != MD_IDLE;
   // divide by zero leaves remainder = |x| and quotient = all ones, so only the quotient sign fix is masked
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
         acc <= '0;
         opd <= '0;
         is_div <= 1'b0;
         neg_hi <= 1'b0;
         neg_lo <= 1'b0;
         bus.done <= 1'b0;
         bus.hi <= '0;
         bus.lo <= '0;
      end else begin
         bus.done <= state == MD_FIX;
         if (state == MD_IDLE && bus.start) begin
            if (bus.op == MD_MTHI) bus.hi <= bus.x;
            if (bus.op == MD_MTLO) bus.lo <= bus.x;
            if (bus.op <= MD_DIVU) begin
               is_div <= bus.op[1];
               cnt <= '0;
               opd <= bus.op[1] ? mag[31:0] : mag[63:32];
               acc <= {32'd0, bus.op[1] ? mag[63:32] : mag[31:0]};
               neg_hi <= bus.op[1] ? sx : sx ^ sy;
               neg_lo <= (sx ^ sy) && bus.y != 32'd0;
            end
         end
         if (state == MD_CALC) begin
            acc <= step;
            cnt <= cnt + 5'd1;
         end
         if (state == MD_FIX) begin
            bus.hi <= res[63:32];
            bus.lo <= res[31:0];
         end
      end
   end
endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: random and directed checks of hilo_muldiv against an arithmetic reference model
module tb_hilo_muldiv;
   import mips_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   hilo_muldiv_if bus ();
   hilo_muldiv dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      logic [63:0] ua = {32'd0, a};
      logic [63:0] ub = {32'd0, b};
      longint p;
      logic [63:0] r;
      r = '0;
      case (o)
         MD_MULT: begin p = sa * sb; r = p; end
         MD_MULTU: r = ua * ub;
         MD_DIV: begin
            if (b == 0) r = {a, 32'hFFFFFFFF};
            else begin
               p = sa / sb;
               r[31:0] = p[31:0];
               p = sa % sb;
               r[63:32] = p[31:0];
            end
         end
         MD_DIVU: begin
            if (b == 0) r = {a, 32'hFFFFFFFF};
            else begin
               r[31:0] = a / b;
               r[63:32] = a % b;
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction
   task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      if (o <= MD_DIVU) {m_hi, m_lo} = ref_md(o, a, b);
      else if (o == MD_MTHI) m_hi = a;
      else if (o == MD_MTLO) m_lo = a;
   endtask
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      int lat, nb;
      bus.start = 1'b1;
      bus.op = o;
      bus.x = a;
      bus.y = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      model(o, a, b);
      if (o <= MD_DIVU) begin
         check("done_low_after_accept", 64'(bus.done), 64'd0);
         lat = 0;
         nb = 0;
         while (!bus.done && lat < 40) begin
            if (bus.busy) nb++;
            @(posedge clk);
            #1;
            lat++;
         end
         check("latency", 64'(lat), 64'd33);
         check("busy_cycles", 64'(nb), 64'd33);
         check("busy_low_at_done", 64'(bus.busy), 64'd0);
      end else begin
         check("short_busy", 64'(bus.busy), 64'd0);
         check("short_done", 64'(bus.done), 64'd0);
      end
      check("hi", 64'(bus.hi), 64'(m_hi));
      check("lo", 64'(bus.lo), 64'(m_lo));
   endtask
   typedef struct {logic [2:0] o; logic [31:0] a, b, ehi, elo;} vec_t;
   vec_t vecs[7] = '{
      '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1},
      '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD},
      '{MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3},
      '{MD_DIVU,  32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF},
      '{MD_DIV,   32'h12345678, 32'd0,        32'h12345678, 32'hFFFFFFFF},
      '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000}
   };
   initial begin
      int nd;
      logic [2:0] o;
      logic [31:0] a, b;
      bus.start = 1'b0;
      bus.op = '0;
      bus.x = '0;
      bus.y = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_hi", 64'(bus.hi), 64'd0);
      check("rst_lo", 64'(bus.lo), 64'd0);
      foreach (vecs[i]) begin
         issue(vecs[i].o, vecs[i].a, vecs[i].b);
         check("vec_hi", 64'(bus.hi), 64'(vecs[i].ehi));
         check("vec_lo", 64'(bus.lo), 64'(vecs[i].elo));
      end
      issue(MD_MTHI, 32'hAAAA5555, 32'd0);
      check("mthi", 64'(bus.hi), 64'hAAAA5555);
      // MTLO issued mid-MULT must be ignored
      bus.start = 1'b1;
      bus.op = MD_MULT;
      bus.x = 32'hFFFF1234;
      bus.y = 32'h00076543;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      model(MD_MULT, 32'hFFFF1234, 32'h00076543);
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op = MD_MTLO;
      bus.x = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      nd = 0;
      while (!bus.done && nd < 40) begin
         @(posedge clk);
         #1;
         nd++;
      end
      check("mtlo_busy_done", 64'(bus.done), 64'd1);
      check("mtlo_busy_hi", 64'(bus.hi), 64'(m_hi));
      check("mtlo_busy_lo", 64'(bus.lo), 64'(m_lo));
      // MULTU re-issued every CALC cycle: one operation, one done pulse
      bus.start = 1'b1;
      bus.op = MD_MULTU;
      bus.x = 32'd1000;
      bus.y = 32'd3000;
      @(posedge clk);
      #1;
      model(MD_MULTU, 32'd1000, 32'd3000);
      bus.x = 32'd77;
      bus.y = 32'd99;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 31) bus.start = 1'b0;
         if (bus.done) nd++;
         @(posedge clk);
         #1;
      end
      check("held_done_count", 64'(nd), 64'd1);
      check("held_hi", 64'(bus.hi), 64'(m_hi));
      check("held_lo", 64'(bus.lo), 64'(m_lo));
      // reset at cycle 10 of a DIV, with a start dropped in the reset cycle
      bus.start = 1'b1;
      bus.op = MD_DIV;
      bus.x = 32'd100;
      bus.y = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.start = 1'b1;
      bus.op = MD_MTHI;
      bus.x = 32'h5A5A5A5A;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.start = 1'b0;
      m_hi = '0;
      m_lo = '0;
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_hi", 64'(bus.hi), 64'd0);
      check("abort_lo", 64'(bus.lo), 64'd0);
      nd = 0;
      for (int i = 0; i < 35; i++) begin
         if (bus.done || bus.busy) nd++;
         @(posedge clk);
         #1;
      end
      check("abort_quiet", 64'(nd), 64'd0);
      issue(MD_MULTU, 32'd6, 32'd7);
      check("mul67_hi", 64'(bus.hi), 64'd0);
      check("mul67_lo", 64'(bus.lo), 64'd42);
      for (int i = 0; i < 24; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         if ($urandom_range(0, 3) == 0) b = -32'($urandom_range(1, 20));
         issue(o, a, b);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multi-cycle multiply/divide unit that owns the HI/LO register pair of the MIPS datapath. It complements the single-cycle ALU. The decode stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO here and stalls on `busy`. MFHI/MFLO read the registered `hi`/`lo` outputs directly. Long operations are iterative, one bit per cycle, so no 32x32 array multiplier or divider sits on the critical path.

## Interface
Parameters:
- none; operand width fixed at 32, iteration count fixed at 32.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe; sampled only while idle.
- `op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `x`  in  32  rs operand / dividend / MTHI-MTLO source.
- `y`  in  32  rt operand / divisor.
- `busy`  out  1  high while a MULT/DIV is in flight; the CPU stalls on it.
- `done`  out  1  one-cycle pulse when `hi`/`lo` are updated by MULT/DIV.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- States: IDLE, CALC, FIX.
- IDLE with `start` and op 0-3:
  - Latch operand magnitudes and sign flags. Unsigned ops use the raw values.
  - Clear the accumulator and set the counter to 0.
  - Go to CALC.
- IDLE with `start` and op 4: `hi` <= `x` at that edge. State stays IDLE; no `done`.
- IDLE with `start` and op 5: `lo` <= `x` at that edge. State stays IDLE; no `done`.
- IDLE with `start` and op 6/7: nothing happens.
- CALC, multiply: one shift-add step per cycle on a 64-bit product register.
- CALC, divide: one restoring step per cycle with a 33-bit partial remainder; quotient bits shift in from the LSB.
- CALC exit: after 32 steps (counter 31 -> wraps) go to FIX.
- FIX:
  - Negate the product if the operand signs differ (signed MULT only).
  - Negate the quotient if the dividend and divisor signs differ (signed DIV only).
  - Give the remainder the sign of the dividend (signed DIV only).
  - Write `hi` (product[63:32] / remainder) and `lo` (product[31:0] / quotient).
  - Pulse `done` and return to IDLE.
- Divide by zero (`y`==0, DIV or DIVU): fixed result `lo`=32'hFFFFFFFF, `hi`=`x` as issued. This overrides the sign fix. Latency is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: wraps to `lo`=0x80000000, `hi`=0. No trap.
- `start` while `busy`: ignored for every op, including MTHI/MTLO. The issuing stage holds it.
- `rst` in any state:
  - Aborts the operation. Next cycle: IDLE, `busy`=0, `done`=0, `hi`=`lo`=0.
  - A `start` in the same cycle as `rst` is dropped.

## Timing
- `start` sampled at edge N (idle): CALC during cycles N+1..N+32, FIX at cycle N+33.
- `busy` high for exactly 33 cycles after edge N; it falls after edge N+33.
- `hi`/`lo` show the new values and `done`=1 in the cycle after edge N+33 (34-cycle latency). `done` is low the next cycle.
- A back-to-back `start` can be accepted at edge N+34, i.e. while `done` is high.
- MTHI/MTLO: `hi`/`lo` visible the cycle after the accepting edge, with 1-cycle latency and no `busy` assertion.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mips_pkg` holds:
  - the `op` encodings (`MD_MULT` .. `MD_MTLO`);
  - the state enum (`MD_IDLE`, `MD_CALC`, `MD_FIX`);
  - the iteration-count constant 32.
- One sub-module, `muldiv_signfix`, is natural: combinational absolute value on entry and conditional two's-complement negation in FIX. It is instantiated once for operands and once for results.

## Test plan
- MULTU x=0xFFFFFFFF, y=0xFFFFFFFF -> after 34 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` one cycle, `busy` 33 cycles.
- MULT x=0xFFFFFFFD (-3), y=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. DIV x=0xFFFFFFF9 (-7), y=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 -> `lo`=3, `hi`=1.
- DIVU and DIV x=0x12345678, y=0 -> `lo`=0xFFFFFFFF, `hi`=0x12345678. DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI x=0xAAAA5555 while idle -> `hi`=0xAAAA5555 next cycle, `busy`/`done` stay 0. MTLO issued at cycle 5 of a MULT -> ignored, and the MULT result is intact.
- `start` with MULTU re-asserted every cycle during CALC -> only one operation runs and one `done` pulse appears. A new op accepted in the `done` cycle completes 34 cycles later.
- `rst` asserted at cycle 10 of a DIV -> next cycle `busy`=0, `hi`=`lo`=0, no `done`. A following MULTU 6*7 gives `lo`=42, `hi`=0.
